// File: rtl/uart_fifo_core.sv
// ============================================================================
// Module      : uart_fifo_core (with helper uart_fifo_core_fifo)
// Description : Full-duplex UART core. It has a programmable baud divisor,
//               DATA_W-bit frames, 1 or 2 stop bits, TX/RX FIFOs with
//               valid/ready handshakes, RTS/CTS flow control and sticky
//               error flags.
//               Optional feature macro: UART_PARITY_EN. When it is defined,
//               a parity bit is added after the data bits and checked on
//               receive, with parity_odd selecting odd or even parity.
// Ports       : clk, nReset (async active-low)
//               wr_data/wr_valid/wr_ready   host -> TX FIFO
//               rd_data/rd_valid/rd_ready   RX FIFO -> host (fall-through)
//               div_in/div_load             baud divisor (bit = D+1 clks)
//               parity_odd, clear, err_clr  control
//               rx/tx/cts/rts               pads
//               tx_busy, tx_count, rx_count status
//               frame_err/parity_err/overrun sticky flags
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_fifo_core_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     nReset,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int             AW   = $clog2(DEPTH);
    localparam logic [AW:0]    FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    // A pop needs a stored entry. A push at full is allowed only when the
    // same-cycle pop frees a slot.
    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && ((count_q != FULL) || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
endmodule

module uart_fifo_core #(
    parameter int DATA_W      = 8,
    parameter int FIFO_DEPTH  = 8,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 5207,
    parameter int STOP_BITS   = 1
) (
    input  logic                          clk,
    input  logic                          nReset,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    input  logic [DIV_W-1:0]              div_in,
    input  logic                          div_load,
    input  logic                          parity_odd,
    input  logic                          clear,
    input  logic                          err_clr,
    input  logic                          rx,
    output logic                          tx,
    input  logic                          cts,
    output logic                          rts,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   tx_count,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun
);
    localparam int               CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [DIV_W-1:0] DIV_MIN   = DIV_W'(3);
    localparam logic [DIV_W-1:0] DIV_RST   = DIV_W'(DEFAULT_DIV);
    localparam logic [3:0]       LAST_DATA = 4'(DATA_W - 1);
    localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    // ------------------------------------------------------------------
    // Divisor shadow. Each engine copies it at its own frame start.
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_shadow_q, div_shadow_d;

    always_comb begin
        div_shadow_d = div_shadow_q;
        if (div_load) begin
            div_shadow_d = (div_in < DIV_MIN) ? DIV_MIN : div_in;
        end
    end

    // ------------------------------------------------------------------
    // FIFOs
    // ------------------------------------------------------------------
    logic              tx_pop, tx_push;
    logic [DATA_W-1:0] tx_head;
    logic              rx_push_req, rd_pop;

    assign wr_ready = (tx_count < CW'(FIFO_DEPTH));
    assign tx_push  = wr_valid && wr_ready;
    assign rd_valid = (rx_count != '0);
    assign rd_pop   = rd_valid && rd_ready;
    assign rts      = (rx_count <= CW'(FIFO_DEPTH - 2));

    uart_fifo_core_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk    (clk),
        .nReset (nReset),
        .clear  (clear),
        .push   (tx_push),
        .pop    (tx_pop),
        .wdata  (wr_data),
        .rdata  (tx_head),
        .count  (tx_count)
    );

    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;

    uart_fifo_core_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk    (clk),
        .nReset (nReset),
        .clear  (clear),
        .push   (rx_push_req),
        .pop    (rd_pop),
        .wdata  (rx_shift_q),
        .rdata  (rd_data),
        .count  (rx_count)
    );

    // ------------------------------------------------------------------
    // TX engine. The line output is registered from the current state, so
    // the start bit shows one cycle after the FSM leaves IDLE.
    // ------------------------------------------------------------------
    logic [2:0]        tx_state_q, tx_state_d;
    logic [DIV_W-1:0]  tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
    logic [3:0]        tx_bit_q, tx_bit_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic              tx_line_q, tx_line_d;
    logic              tx_tick;
`ifdef UART_PARITY_EN
    logic              tx_par_q, tx_par_d;
`endif

    assign tx_tick = (tx_cnt_q == tx_div_q);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_div_d   = tx_div_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_line_d  = 1'b1;
        tx_pop     = 1'b0;
`ifdef UART_PARITY_EN
        tx_par_d   = tx_par_q;
`endif
        if (tx_state_q != S_IDLE) begin
            tx_cnt_d = tx_tick ? '0 : tx_cnt_q + DIV_W'(1);
        end
        case (tx_state_q)
            S_IDLE: begin
                // cts is only looked at here, so a frame in flight always completes.
                if ((tx_count != '0) && cts) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_head;
                    tx_div_d   = div_shadow_q;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
`ifdef UART_PARITY_EN
                    tx_par_d   = (^tx_head) ^ parity_odd;
`endif
                    tx_state_d = S_START;
                end
            end
            S_START: begin
                tx_line_d = 1'b0;
                if (tx_tick) begin
                    tx_state_d = S_DATA;
                end
            end
            S_DATA: begin
                tx_line_d = tx_shift_q[0];
                if (tx_tick) begin
                    tx_shift_d = tx_shift_q >> 1;
                    if (tx_bit_q == LAST_DATA) begin
                        tx_bit_d = '0;
`ifdef UART_PARITY_EN
                        tx_state_d = S_PARITY;
`else
                        tx_state_d = S_STOP;
`endif
                    end else begin
                        tx_bit_d = tx_bit_q + 4'd1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                tx_line_d = tx_par_q;
                if (tx_tick) begin
                    tx_state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (tx_tick) begin
                    if (tx_bit_q == LAST_STOP) begin
                        tx_state_d = S_IDLE;
                    end else begin
                        tx_bit_d = tx_bit_q + 4'd1;
                    end
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
    end

    assign tx      = tx_line_q;
    assign tx_busy = (tx_state_q != S_IDLE);

    // ------------------------------------------------------------------
    // RX engine
    // ------------------------------------------------------------------
    logic              rx_s1_q, rx_s2_q, rx_prev_q;
    logic [2:0]        rx_state_q, rx_state_d;
    logic [DIV_W-1:0]  rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
    logic [3:0]        rx_bit_q, rx_bit_d;
    logic              rx_tick, rx_fall, rx_done, rx_par_ok;
    logic              frame_set, parity_set, overrun_set;
    logic              frame_err_q, frame_err_d, overrun_q, overrun_d;
`ifdef UART_PARITY_EN
    logic              rx_par_q, rx_par_d;
    logic              parity_err_q, parity_err_d;
`endif

    assign rx_tick = (rx_cnt_q == rx_div_q);
    assign rx_fall = rx_prev_q && !rx_s2_q;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_div_d   = rx_div_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_done    = 1'b0;
`ifdef UART_PARITY_EN
        rx_par_d   = rx_par_q;
`endif
        if (rx_state_q != S_IDLE) begin
            rx_cnt_d = rx_tick ? '0 : rx_cnt_q + DIV_W'(1);
        end
        case (rx_state_q)
            S_IDLE: begin
                if (rx_fall) begin
                    rx_div_d   = div_shadow_q;
                    rx_cnt_d   = '0;
                    rx_state_d = S_START;
                end
            end
            S_START: begin
                // Mid-start-bit sample. A high line here means the edge was a glitch.
                if (rx_cnt_q == (rx_div_q >> 1)) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (rx_tick) begin
                    rx_shift_d = {rx_s2_q, rx_shift_q[DATA_W-1:1]};
                    if (rx_bit_q == LAST_DATA) begin
`ifdef UART_PARITY_EN
                        rx_state_d = S_PARITY;
`else
                        rx_state_d = S_STOP;
`endif
                    end else begin
                        rx_bit_d = rx_bit_q + 4'd1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (rx_tick) begin
                    rx_par_d   = rx_s2_q;
                    rx_state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // Only the first stop bit is checked. Returning to IDLE mid-bit
                // lets a back-to-back start edge be caught.
                if (rx_tick) begin
                    rx_done    = 1'b1;
                    rx_state_d = S_IDLE;
                end
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

`ifdef UART_PARITY_EN
    assign rx_par_ok = (((^rx_shift_q) ^ parity_odd) == rx_par_q);
`else
    assign rx_par_ok = 1'b1;
    logic unused_parity_odd;
    assign unused_parity_odd = parity_odd;
`endif

    assign frame_set   = rx_done && !rx_s2_q;
    assign parity_set  = rx_done && rx_s2_q && !rx_par_ok;
    assign rx_push_req = rx_done && rx_s2_q && rx_par_ok;
    assign overrun_set = rx_push_req && (rx_count == CW'(FIFO_DEPTH)) && !rd_pop;

    // A new error in the same cycle as err_clr wins.
    assign frame_err_d = (frame_err_q && !err_clr) || frame_set;
    assign overrun_d   = (overrun_q && !err_clr) || overrun_set;
    assign frame_err   = frame_err_q;
    assign overrun     = overrun_q;
`ifdef UART_PARITY_EN
    assign parity_err_d = (parity_err_q && !err_clr) || parity_set;
    assign parity_err   = parity_err_q;
`else
    assign parity_err   = 1'b0;
    logic unused_parity_set;
    assign unused_parity_set = parity_set;
`endif

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            div_shadow_q <= DIV_RST;
            tx_state_q   <= S_IDLE;
            tx_cnt_q     <= '0;
            tx_div_q     <= DIV_RST;
            tx_bit_q     <= '0;
            tx_shift_q   <= '0;
            tx_line_q    <= 1'b1;
            rx_s1_q      <= 1'b1;
            rx_s2_q      <= 1'b1;
            rx_prev_q    <= 1'b1;
            rx_state_q   <= S_IDLE;
            rx_cnt_q     <= '0;
            rx_div_q     <= DIV_RST;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_PARITY_EN
            tx_par_q     <= 1'b0;
            rx_par_q     <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            div_shadow_q <= div_shadow_d;
            tx_state_q   <= tx_state_d;
            tx_cnt_q     <= tx_cnt_d;
            tx_div_q     <= tx_div_d;
            tx_bit_q     <= tx_bit_d;
            tx_shift_q   <= tx_shift_d;
            tx_line_q    <= tx_line_d;
            rx_s1_q      <= rx;
            rx_s2_q      <= rx_s1_q;
            rx_prev_q    <= rx_s2_q;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_div_q     <= rx_div_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
`ifdef UART_PARITY_EN
            tx_par_q     <= tx_par_d;
            rx_par_q     <= rx_par_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end
endmodule

`default_nettype wire

// File: doc/uart_fifo_core.md
# uart_fifo_core

Parametrised full-duplex UART core: programmable baud divisor, configurable data width and stop bits, depth-parametrised TX/RX FIFOs with valid/ready handshakes, RTS/CTS flow control and sticky error flags. It is the next-generation replacement for the fixed 8-bit, fixed-rate-table UART wrapper. It sits between the bus-slave register block (host side) and the chip pads (tx/rx/cts/rts). Baud generation, shift engines and FIFOs are all contained in this block.

## Interface
- DATA_W, 8: frame data bits, legal 5..9.
- FIFO_DEPTH, 8: entries per FIFO, power of two, ≥2.
- DIV_W, 16: divisor register width.
- DEFAULT_DIV, 5207: divisor after reset.
- STOP_BITS, 1: 1 or 2.
- Reset is nReset, asynchronous, active-low. The clock is clk.
- clk  in  1  core clock.
- nReset  in  1  asynchronous active-low reset.
- wr_data  in  DATA_W  TX byte.
- wr_valid  in  1  push request.
- wr_ready  out  1  TX FIFO not full.
- rd_data  out  DATA_W  head of RX FIFO (first-word fall-through).
- rd_valid  out  1  RX FIFO not empty.
- rd_ready  in  1  pop request.
- div_in  in  DIV_W  new divisor.
- div_load  in  1  load div_in.
- parity_odd  in  1  0 = even parity, 1 = odd parity (used only when UART_PARITY_EN is defined).
- clear  in  1  flush both FIFOs.
- err_clr  in  1  clear sticky flags.
- rx  in  1  serial input (asynchronous).
- tx  out  1  serial output.
- cts  in  1  high = peer may receive.
- rts  out  1  high = core can accept frames.
- tx_busy  out  1  TX FSM not IDLE.
- tx_count, rx_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- frame_err, parity_err, overrun  out  1  sticky error flags.

## Operation
- Bit period is D+1 clk cycles, where D is the active divisor. div_load with div_in<3 loads 3.
- A newly loaded divisor is shadowed. Each engine latches it at its next frame start; frames already in progress keep their old rate.
- Frame format: start bit (0), DATA_W data bits LSB first, optional parity bit, then STOP_BITS stop bits (1). The line idles at 1.
- TX FSM states: IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - IDLE leaves only when tx_count>0 and cts=1. On leaving, it pops the FIFO head into the shift register.
  - cts is checked only in IDLE. Deasserting cts mid-frame does not abort the frame.
- RX path: rx passes through a 2-flop synchroniser before any use.
- RX FSM states: IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - IDLE: a synchronised falling edge starts a frame.
  - START samples at D>>1 cycles after the edge. If the sample is 1, it is a false start and the FSM returns to IDLE.
  - After START, each bit is sampled every D+1 cycles.
  - Only the first stop bit is checked.
- RX push conditions on a completed frame:
  - Stop bit sampled 0: frame_err set, byte discarded.
  - Parity mismatch: parity_err set, byte discarded.
  - RX FIFO full with no same-cycle pop: overrun set, byte discarded.
  - Otherwise the byte is pushed.
- FIFOs:
  - Push and pop in the same cycle both succeed at any occupancy, including full (RX side) and empty-with-bypass forbidden (TX side: a pop needs a stored entry).
  - Pointers wrap modulo FIFO_DEPTH.
  - clear empties both FIFOs next cycle. It does not abort in-flight frames; a completing RX frame after clear is pushed normally. clear has priority over a same-cycle push/pop.
- rts = (rx_count ≤ FIFO_DEPTH−2). wr_ready = (tx_count < FIFO_DEPTH).
- Sticky flags hold until err_clr. If err_clr and a new error occur in the same cycle, the flag stays set.

## Timing
- Reset values: tx=1, rts=1, wr_ready=1, rd_valid=0, rd_data=0, tx_busy=0, counts=0, all error flags 0, active divisor=DEFAULT_DIV, both FSMs IDLE.
- Write accepted at edge N. The TX FSM sees a non-empty FIFO after N+1, and the start bit appears on tx from cycle N+2.
- Receive latency: rd_valid rises 1 cycle after the stop-bit sample. The stop-bit sample is (D>>1) + (1 + DATA_W + parity + 1 − 1)·(D+1) + 2 sync cycles after the falling edge on rx.
- A pop occurs at a cycle with rd_valid and rd_ready both high. The next entry (or rd_valid=0) is visible the following cycle.
- nReset asserted mid-frame: immediate return to reset values. tx goes to 1 asynchronously.

## Configuration
- UART_PARITY_EN defined: a PARITY state exists in both FSMs. TX inserts the parity bit computed per parity_odd. RX checks the parity bit and sets parity_err on mismatch.
- UART_PARITY_EN undefined: no parity bit on the line, PARITY states are removed, parity_odd is ignored, and parity_err is tied to 0.

## Test plan
- Reset, load D=7, write 0xA5 → start bit at N+2; tx sequence 0,1,0,1,0,0,1,0,1,1 with each bit held 8 cycles; tx_busy high for 80 cycles.
- Loopback tx→rx with D=7, write 0x3C, 0xFF, 0x00 → rx_count reaches 3; pops return 0x3C, 0xFF, 0x00 in that order; no error flags set.
- Inject 9 frames into rx with no pops, FIFO_DEPTH=8 → rts falls when rx_count=7; 8 bytes stored; overrun=1; the 9th byte is lost.
- Drive the stop bit low on frame 0x55 → frame_err=1 and rx_count unchanged; err_clr → frame_err=0.
- With UART_PARITY_EN and parity_odd=0, send 0x07 → parity bit on the line is 1. With a corrupted parity bit → parity_err=1 and the byte is discarded.
- cts=0 with 2 bytes queued → tx stays 1 and tx_count=2. Raise cts → first frame starts. Drop cts mid-frame → that frame completes, the second is held until cts=1.
